// File: rtl/clk_div_pkg.sv
// -----------------------------------------------------------------------------
// clk_div_pkg
// Shared constants and helpers for the programmable clock divider.
//   CLK_DIV_MIN      smallest divisor the hardware will run with
//   clk_div_clamp    raises a requested divisor to CLK_DIV_MIN if it is below
//   clk_div_half_up  ceil(n/2), one bit wider than its input so n = all-ones
//                    cannot overflow
// The helpers work on 32-bit operands; callers cast their WIDTH-bit values in
// and out, so WIDTH up to 32 is supported.
// -----------------------------------------------------------------------------
package clk_div_pkg;

    localparam int unsigned CLK_DIV_MIN = 2;

    function automatic logic [31:0] clk_div_clamp(input logic [31:0] v);
        return (v < CLK_DIV_MIN) ? 32'(CLK_DIV_MIN) : v;
    endfunction

    function automatic logic [32:0] clk_div_half_up(input logic [31:0] n);
        return ({1'b0, n} + 33'd1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_prog_if.sv
// -----------------------------------------------------------------------------
// clk_div_prog_if
// Control/status bundle of the programmable clock divider.
//   en        count enable                        (master -> slave)
//   div_wr    one-cycle divisor write strobe      (master -> slave)
//   div_val   requested divisor                   (master -> slave)
//   clr       synchronous phase restart, only present when
//             CLK_DIV_SYNC_CLR_EN is defined      (master -> slave)
//   tick      one-cycle pulse per output period   (slave -> master)
//   clk_out   registered square wave              (slave -> master)
//   div_act   divisor currently in force          (slave -> master)
//   upd_pend  a written divisor awaits a boundary (slave -> master)
//   div_err   sticky "write was clamped" flag     (slave -> master)
// -----------------------------------------------------------------------------
interface clk_div_prog_if #(
    parameter int WIDTH = 16
) ();

    logic             en;
    logic             div_wr;
    logic [WIDTH-1:0] div_val;
`ifdef CLK_DIV_SYNC_CLR_EN
    logic             clr;
`endif
    logic             tick;
    logic             clk_out;
    logic [WIDTH-1:0] div_act;
    logic             upd_pend;
    logic             div_err;

    modport master (
`ifdef CLK_DIV_SYNC_CLR_EN
        output clr,
`endif
        output en, div_wr, div_val,
        input  tick, clk_out, div_act, upd_pend, div_err
    );

    modport slave (
`ifdef CLK_DIV_SYNC_CLR_EN
        input  clr,
`endif
        input  en, div_wr, div_val,
        output tick, clk_out, div_act, upd_pend, div_err
    );

endinterface

// File: rtl/clk_div_cnt.sv
// -----------------------------------------------------------------------------
// clk_div_cnt
// Phase counter and output decode of the programmable divider.
// The counter runs 0 .. n_act-1 while en is high and wraps to 0. tick and
// clk_out are decoded from the *next* counter value and the *next* divisor,
// so once registered they line up with the counter value they describe.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   en          advance enable
//   restart     force the counter (and decode) back to phase 0
//   n_act       divisor in force this cycle
//   n_nxt       divisor that will be in force after this edge
//   wrap        this cycle ends a period (boundary taken on the next edge)
//   tick        period pulse, high while cnt == n_act-1 and en is high
//   clk_out     low for ceil(n_act/2) phases, high for the rest
// -----------------------------------------------------------------------------
module clk_div_cnt
    import clk_div_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             restart,
    input  logic [WIDTH-1:0] n_act,
    input  logic [WIDTH-1:0] n_nxt,
    output logic             wrap,
    output logic             tick,
    output logic             clk_out
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_nxt;
    logic             last_q;
    logic             clk_out_q;

    // last_q is exactly (cnt_q == n_act-1) because it is registered from the
    // next counter and next divisor, so the boundary needs no subtractor on
    // the current-cycle path; qualifying with en makes stalls hold the pulse
    // off instead of stretching it.
    assign wrap = last_q & en;

    always_comb begin
        cnt_nxt = cnt_q;
        if (restart || wrap) begin
            cnt_nxt = '0;
        end else if (en) begin
            cnt_nxt = cnt_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            last_q    <= 1'b0;
            clk_out_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_nxt;
            last_q    <= (cnt_nxt == n_nxt - WIDTH'(1));
            // Compare in WIDTH+1 bits: ceil(n/2) of an all-ones n needs it.
            clk_out_q <= (33'(cnt_nxt) >= clk_div_half_up(32'(n_nxt)));
        end
    end

    assign tick    = wrap;
    assign clk_out = clk_out_q;

endmodule

// File: rtl/clk_div_prog.sv
// -----------------------------------------------------------------------------
// clk_div_prog
// Runtime-programmable clock divider. Produces a one-cycle tick every N_act
// cycles of clk and a registered square wave clk_out of period N_act.
// A written divisor is held pending and only takes effect at a period
// boundary, so clk_out never glitches and no period is cut short.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset; aborts the period and drops any
//          pending divisor
//   bus    clk_div_prog_if.slave: en, div_wr, div_val, [clr] in;
//          tick, clk_out, div_act, upd_pend, div_err out
// Parameters:
//   WIDTH        divisor / phase counter width (up to 32)
//   DEFAULT_DIV  divisor in force after reset (2 .. 2^WIDTH-1)
// Optional feature:
//   CLK_DIV_SYNC_CLR_EN  adds bus.clr, a synchronous phase restart that also
//                        applies any pending divisor immediately, regardless
//                        of en and ahead of the normal boundary rule.
// -----------------------------------------------------------------------------
module clk_div_prog
    import clk_div_pkg::*;
#(
    parameter int          WIDTH       = 16,
    parameter int unsigned DEFAULT_DIV = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    clk_div_prog_if.slave bus
);

    logic [WIDTH-1:0] div_act_q;
    logic [WIDTH-1:0] pend_q;
    logic             upd_pend_q;
    logic             div_err_q;

    logic [WIDTH-1:0] wr_val;
    logic             wr_bad;
    logic [WIDTH-1:0] n_nxt;
    logic             wrap;
    logic             restart;
    logic             apply;
    logic             tick;
    logic             clk_out;

    assign wr_val = WIDTH'(clk_div_clamp(32'(bus.div_val)));
    assign wr_bad = bus.div_wr && (32'(bus.div_val) < CLK_DIV_MIN);

`ifdef CLK_DIV_SYNC_CLR_EN
    assign restart = bus.clr;
`else
    assign restart = 1'b0;
`endif

    // A divisor change is allowed only where a period starts afresh: at a
    // taken boundary or on a synchronous restart.
    assign apply = restart | wrap;

    // A write landing on the apply cycle bypasses the pending register, so it
    // is the last write and wins over an older pending value.
    always_comb begin
        n_nxt = div_act_q;
        if (apply) begin
            if (bus.div_wr) begin
                n_nxt = wr_val;
            end else if (upd_pend_q) begin
                n_nxt = pend_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_act_q  <= WIDTH'(DEFAULT_DIV);
            pend_q     <= '0;
            upd_pend_q <= 1'b0;
            div_err_q  <= 1'b0;
        end else begin
            div_act_q <= n_nxt;
            if (apply) begin
                upd_pend_q <= 1'b0;
            end else if (bus.div_wr) begin
                pend_q     <= wr_val;
                upd_pend_q <= 1'b1;
            end
            if (wr_bad) begin
                div_err_q <= 1'b1;
            end
        end
    end

    clk_div_cnt #(
        .WIDTH (WIDTH)
    ) u_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (bus.en),
        .restart (restart),
        .n_act   (div_act_q),
        .n_nxt   (n_nxt),
        .wrap    (wrap),
        .tick    (tick),
        .clk_out (clk_out)
    );

    assign bus.tick     = tick;
    assign bus.clk_out  = clk_out;
    assign bus.div_act  = div_act_q;
    assign bus.upd_pend = upd_pend_q;
    assign bus.div_err  = div_err_q;

endmodule

// File: doc/clk_div_prog.md
# clk_div_prog

Runtime-programmable clock divider. It produces a one-cycle `tick` enable pulse every N cycles of `clk`, and a registered square-wave `clk_out` with period N. N can be reloaded at runtime. A new N takes effect only at a period boundary, so `clk_out` never glitches and no period is ever truncated. It replaces fixed power-of-two dividers such as the 25 MHz VGA pixel-clock tap, e.g. N=4 from 100 MHz.

## Interface
Parameters:
- `WIDTH`, 16: width of the divisor and phase counter.
- `DEFAULT_DIV`, 4: divisor loaded at reset. Must be ≥2 and < 2^WIDTH.

Ports:
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  count enable. When low, the counter holds, `tick` is 0 and `clk_out` holds its value.
- `div_wr`  in  1  one-cycle write strobe for `div_val`.
- `div_val`  in  WIDTH  requested divisor N.
- `tick`  out  1  high for exactly one cycle per period, while cnt == N_act−1.
- `clk_out`  out  1  flop output: low for ceil(N_act/2) cycles, then high for floor(N_act/2) cycles.
- `div_act`  out  WIDTH  divisor currently in force.
- `upd_pend`  out  1  a written divisor is waiting for the next period boundary.
- `div_err`  out  1  sticky flag: a write with `div_val` < 2 was clamped to 2.

## Operation
- Internal phase counter `cnt` runs 0 … N_act−1 and wraps to 0. It advances only on cycles where `en` = 1.
- `tick` and `clk_out` are flops computed from the next value of `cnt`, so both are aligned with the current `cnt`:
  - `tick` = (cnt == N_act−1) && en.
  - `clk_out` = (cnt ≥ ceil(N_act/2)).
- Write path:
  - `div_wr` = 1 latches clamp(`div_val`) into the pending register and sets `upd_pend`.
  - clamp(v) = 2 if v < 2, otherwise v. A clamped write sets `div_err`; only reset clears `div_err`.
  - A second write while `upd_pend` = 1 overwrites the pending value; the last write wins.
- Update at the period boundary: on the cycle where cnt == N_act−1 and `en` = 1, the next edge does all of the following:
  - cnt ← 0;
  - if a divisor is pending (including one written on this same cycle), N_act ← pending and `upd_pend` ← 0.
- `en` low on the boundary cycle: the update waits until the boundary is actually taken.
- Reset values: cnt = 0, `tick` = 0, `clk_out` = 0, `div_act` = `DEFAULT_DIV`, `upd_pend` = 0, `div_err` = 0.
- Asserting `rst_n` low mid-period aborts the period immediately and discards any pending divisor.
- Arithmetic is unsigned WIDTH-bit. ceil(N/2) = (N+1)>>1, computed in WIDTH+1 bits so no overflow occurs at N = 2^WIDTH−1.

## Timing
- With `en` held high after reset release, the first `tick` is high in the cycle after the (N−1)th rising edge. Subsequent ticks are exactly N cycles apart.
- Write latency: `upd_pend` rises the cycle after `div_wr`. `div_act` changes the cycle after the boundary, in the same cycle cnt = 0.
- The first period at the new N begins with `clk_out` low, so there is no runt pulse.
- Write-to-effect worst case is N_old cycles.

## Configuration
- `CLK_DIV_SYNC_CLR_EN` defined: adds input port `clr` (1 bit). When `clr` = 1, the next edge sets cnt ← 0, `tick` ← 0, `clk_out` ← 0, and applies any pending divisor immediately, regardless of `en`. `clr` has priority over the boundary rule. `div_wr` in the same cycle as `clr` is applied by that `clr`.
- Not defined: the `clr` port is absent. Phase is restarted only by `rst_n`.

## Structure
- Package `clk_div_pkg` holds:
  - constant `CLK_DIV_MIN` = 2;
  - function `clk_div_clamp(v)`;
  - function `clk_div_half_up(n)` (ceil(n/2)).
- One sub-module, `clk_div_cnt`: phase counter plus `tick`/`clk_out` decode flops, taking N_act as an input.
- Top level `clk_div_prog`: pending register, update arbitration, error flag, and the optional `clr`.

## Test plan
- Reset with `DEFAULT_DIV` = 4, `en` = 1 → `clk_out` pattern 0,0,1,1 repeating; `tick` high on every 4th cycle; `div_act` = 4.
- Write `div_val` = 5 at cnt = 1 → `upd_pend` = 1 for the rest of the 4-period. Then `div_act` = 5; `clk_out` low 3 cycles, high 2; ticks 5 apart, with no short period at the switch.
- Write 7 then 3 before the boundary (N=4) → `div_act` becomes 3. Write 6 in the `tick` cycle → applied at that boundary.
- Write `div_val` = 0 → `div_err` = 1 and N = 2 after the boundary. `div_err` stays set across later valid writes until `rst_n`.
- `en` = 0 for 3 cycles with cnt = 3 (N=4) → `tick` stays 0, cnt and `clk_out` hold. `tick` fires on the first cycle `en` returns high.
- `rst_n` pulsed low at cnt = 2 with a pending 9 → all outputs at reset values, `div_act` = 4, `upd_pend` = 0. With `CLK_DIV_SYNC_CLR_EN` defined, `clr` at cnt = 2 with pending 9 → cnt = 0 and `div_act` = 9 on the next cycle.
